// File: rtl/serialize_pkg.sv
// serialize_pkg: shared state encoding and width helpers for the lane serializer.
package serialize_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  function automatic int cnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction
  function automatic int eot_bit(input int w_lane);
    return w_lane;
  endfunction
endpackage

// File: rtl/serialize_if.sv
// serialize_if: word-in / lane-out handshake bundle for serialize.
// With SERIALIZE_ACTIVE_EN the active-lane count rides above the lanes in din_data.
interface serialize_if import serialize_pkg::*; #(parameter int LANES = 4, parameter int W_LANE = 8);
`ifdef SERIALIZE_ACTIVE_EN
  localparam int DW = LANES * W_LANE + cnt_w(LANES);
`else
  localparam int DW = LANES * W_LANE;
`endif
  logic din_valid;
  logic din_ready;
  logic [DW-1:0] din_data;
  logic dout_valid;
  logic dout_ready;
  logic [eot_bit(W_LANE):0] dout_data;
  modport slave (input din_valid, din_data, dout_ready, output din_ready, dout_valid, dout_data);
  modport master (output din_valid, din_data, dout_ready, input din_ready, dout_valid, dout_data);
endinterface

// File: rtl/serialize.sv
// serialize: holds one word and emits its lanes 0..last, flagging eot on the last lane.
// SERIALIZE_ACTIVE_EN adds a per-word active-lane count taken from the din_data MSBs.
module serialize import serialize_pkg::*; #(
  parameter int LANES = 4,
  parameter int W_LANE = 8
) (
  input logic clk,
  input logic rst,
  serialize_if.slave bus
);
  localparam int CNTW = $clog2(LANES);
  localparam int LW = LANES * W_LANE;
  localparam int EOT = eot_bit(W_LANE);
`ifdef SERIALIZE_ACTIVE_EN
  localparam int CW = cnt_w(LANES);
  localparam int DW = LW + CW;
`else
  localparam int DW = LW;
`endif
  state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d, last;
  logic [DW-1:0] word_q, word_d;
  logic [LANES-1:0][W_LANE-1:0] lanes;
  logic is_last, din_hs, dout_hs;
`ifdef SERIALIZE_ACTIVE_EN
  logic [CW-1:0] act, act_m1;
  assign act = word_q[DW-1 -: CW];
  assign act_m1 = act - CW'(1);
  // out-of-range counts (0 or above LANES) fall back to a full word
  assign last = (act == '0 || act > CW'(LANES)) ? CNTW'(LANES - 1) : act_m1[CNTW-1:0];
`else
  assign last = CNTW'(LANES - 1);
`endif
  assign lanes = word_q[LW-1:0];
  assign is_last = cnt_q == last;
  assign din_hs = bus.din_valid && bus.din_ready;
  assign dout_hs = bus.dout_valid && bus.dout_ready;
  assign bus.dout_valid = state_q == BUSY;
  assign bus.din_ready = state_q == IDLE || (is_last && bus.dout_ready);
  assign bus.dout_data[EOT] = is_last;
  assign bus.dout_data[EOT-1:0] = lanes[cnt_q];
  always_comb begin
    state_d = din_hs ? BUSY : (dout_hs && is_last) ? IDLE : state_q;
    cnt_d = din_hs ? '0 : (dout_hs && !is_last) ? cnt_q + CNTW'(1) : cnt_q;
    word_d = din_hs ? bus.din_data : word_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      word_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
    end
  end
endmodule

// File: doc/serialize.md
SERIALIZE -- requirements
Module: serialize

Interface
REQ-001 SHALL have parameter LANES, default 4: number of lanes per input word, minimum 2.
REQ-002 SHALL have parameter W_LANE, default 8: lane width in bits.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port din_valid  input  1  upstream word valid.
REQ-006 SHALL have port din_ready  output  1  word accepted when din_valid & din_ready at rising clk.
REQ-007 SHALL have port din_data  input  LANES*W_LANE (+CW with SERIALIZE_ACTIVE_EN)  lane 0 in the LSBs; active count above lanes when enabled.
REQ-008 SHALL have port dout_valid  output  1  lane valid.
REQ-009 SHALL have port dout_ready  input  1  downstream accept.
REQ-010 SHALL have port dout_data  output  W_LANE+1  lane in [W_LANE-1:0], eot flag in bit W_LANE (queue convention).

Function
REQ-011 SHALL hold the accepted word in an internal register and emit its lanes in order 0,1,...,last, one lane per dout handshake.
REQ-012 SHALL implement two states: IDLE (no word held) and BUSY (word held, lane index cnt valid).
REQ-013 SHALL move IDLE->BUSY on din handshake, loading word and setting cnt=0.
REQ-014 SHALL increment cnt on each dout handshake in BUSY while cnt != last.
REQ-015 SHALL, on dout handshake with cnt == last, go to IDLE, or stay BUSY with new word and cnt=0 if din handshakes in the same cycle.
REQ-016 SHALL drive dout_valid = (state == BUSY), registered.
REQ-017 SHALL drive din_ready = (state == IDLE) | (cnt == last & dout_ready), so back-to-back words give one lane per cycle with no bubble.
REQ-018 SHALL drive dout_data[W_LANE] = (cnt == last), and dout_data[W_LANE-1:0] = lane cnt of the held word.
REQ-019 SHALL have latency of one cycle: a word accepted at edge N gives dout_valid at N+1.
REQ-020 SHALL keep dout_data and dout_valid stable while dout_valid & ~dout_ready (no retraction, no change).
REQ-021 SHALL size cnt as $clog2(LANES) bits and never wrap past last.

Reset
REQ-022 SHALL, while rst is low and independent of clk, force state IDLE, cnt 0, and the word register 0.
REQ-023 SHALL output dout_valid 0, din_ready 1, and dout_data 0 during reset.
REQ-024 SHALL drop any partially emitted word on reset mid-operation, with no eot issued for it.

Configuration
REQ-025 SHALL, with SERIALIZE_ACTIVE_EN defined, take a CW=$clog2(LANES+1)-bit active-lane count from din_data MSBs; last = count-1, and count 0 or count > LANES is treated as LANES.
REQ-026 SHALL, without SERIALIZE_ACTIVE_EN, have din_data exactly LANES*W_LANE bits and last = LANES-1.

Structure
REQ-027 SHALL place the lane-count width function, the eot bit position and the state enum (IDLE, BUSY) in shared package serialize_pkg.
REQ-028 SHALL be a single module; no sub-module is warranted.

Verification
REQ-029 SHALL cover single word 0x44332211, dout_ready held 1 -> dout 0x011,0x022,0x033,0x144 on 4 consecutive cycles, then dout_valid 0.
REQ-030 SHALL cover two back-to-back words, din_valid held 1 -> 8 consecutive dout beats with no bubble, eot on beats 4 and 8, and din_ready high only in the last-lane cycles.
REQ-031 SHALL cover dout_ready low 3 cycles at lane 1 -> dout_data stays 0x022 and din_ready stays 0 throughout.
REQ-032 SHALL cover rst asserted low mid-word at lane 2 -> dout_valid 0 immediately (asynchronous), then next word starts at lane 0.
REQ-033 SHALL cover, with SERIALIZE_ACTIVE_EN, count=2, word 0x..BBAA -> 0x0AA then 0x1BB; count=0 -> 4 lanes emitted.
REQ-034 SHALL cover random valid/ready throttling, 1000 words -> scoreboard order intact, exactly one eot per word.
